// File: rtl/pixel_framebuffer_scanout.sv
// pixel_framebuffer_scanout
//   Accepts the drawing blocks' pixel-plot stream (x, y, colour, plot) into a
//   FB_W x FB_H x 3-bit framebuffer and scans it out continuously as VGA.
//   Each framebuffer pixel is shown as a (1<<SCALE_LOG2)-square block. A clear
//   sweep fills the whole buffer with one colour, one address per cycle.
//
// Ports
//   CLOCK_50      in   system clock
//   resetn        in   asynchronous active-low reset
//   x, y          in   plot coordinates (dropped when outside the buffer)
//   colour        in   plot colour {R,G,B}
//   plot          in   write strobe, one pixel per cycle while high
//   clear_req     in   one-cycle pulse that starts a clear sweep
//   clear_colour  in   fill colour, sampled when clear_req is accepted
//   busy          out  high while a clear sweep runs (clear FSM state)
//   VGA_CLK       out  pixel clock, CLOCK_50 / 2
//   VGA_HS/VS     out  active-low syncs
//   VGA_BLANK     out  high in the visible region
//   VGA_SYNC      out  constant 0
//   VGA_R/G/B     out  each colour bit replicated over 10 DAC bits
//
// Handshake: plot and clear_req are sampled on every CLOCK_50 edge with no
// backpressure; while busy is high both are ignored, so a plot issued during
// a sweep is lost and a clear request cannot restart a running sweep.
module pixel_framebuffer_scanout #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       clear_req,
    input  logic [2:0] clear_colour,
    output logic       busy,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic [9:0] VGA_R,
    output logic [9:0] VGA_G,
    output logic [9:0] VGA_B
);

    localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int AW      = $clog2(FB_SIZE);
    localparam int HW      = $clog2(H_TOT);
    localparam int VW      = $clog2(V_TOT);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // ------------------------------------------------------------------
    // Pixel tick and scan counters
    // ------------------------------------------------------------------
    logic          phase_q;
    logic          tick;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    assign tick = phase_q;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            if (h_cnt_q == HW'(H_TOT - 1)) begin
                h_cnt_d = '0;
                if (v_cnt_q == VW'(V_TOT - 1)) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + VW'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end
    end

    // Sync/visible decode straight from the counters (stage 0)
    logic          hs_c, vs_c, vis_c;
    logic [AW-1:0] scan_addr;

    assign hs_c  = !((int'(h_cnt_q) >= H_VIS + H_FP) && (int'(h_cnt_q) < H_VIS + H_FP + H_SYNC));
    assign vs_c  = !((int'(v_cnt_q) >= V_VIS + V_FP) && (int'(v_cnt_q) < V_VIS + V_FP + V_SYNC));
    assign vis_c = (int'(h_cnt_q) < H_VIS) && (int'(v_cnt_q) < V_VIS);

    // Outside the visible area the address is forced to 0 so the RAM is
    // never indexed past its end during blanking.
    assign scan_addr = vis_c ? AW'((int'(v_cnt_q) >> SCALE_LOG2) * FB_W + (int'(h_cnt_q) >> SCALE_LOG2))
                             : '0;

    // ------------------------------------------------------------------
    // Clear FSM and write-port mux
    // ------------------------------------------------------------------
    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [2:0]    clr_col_q, clr_col_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_col_d  = clr_col_q;
        if (state_q == ST_IDLE) begin
            if (clear_req) begin
                state_d    = ST_SWEEP;
                clr_addr_d = '0;
                clr_col_d  = clear_colour;
            end
        end else begin
            if (clr_addr_q == AW'(FB_SIZE - 1)) begin
                state_d = ST_IDLE;
            end else begin
                clr_addr_d = clr_addr_q + AW'(1);
            end
        end
    end

    assign busy = (state_q == ST_SWEEP);

    logic          plot_ok;
    logic [AW-1:0] plot_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;

    assign plot_ok   = plot && !busy && (int'(x) < FB_W) && (int'(y) < FB_H);
    assign plot_addr = AW'(int'(y) * FB_W + int'(x));
    assign wr_en     = busy || plot_ok;
    assign wr_addr   = busy ? clr_addr_q : plot_addr;
    assign wr_data   = busy ? clr_col_q : colour;

    // ------------------------------------------------------------------
    // Scan pipeline registers
    // ------------------------------------------------------------------
    logic [AW-1:0] rd_addr_q;
    logic          hs1_q, vs1_q, vis1_q;
    logic          hs2_q, vs2_q, vis2_q;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            phase_q    <= 1'b0;
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            rd_addr_q  <= '0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            vis1_q     <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            vis2_q     <= 1'b0;
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            clr_col_q  <= '0;
        end else begin
            phase_q    <= ~phase_q;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_col_q  <= clr_col_d;
            if (tick) begin
                rd_addr_q <= scan_addr;
                hs1_q     <= hs_c;
                vs1_q     <= vs_c;
                vis1_q    <= vis_c;
                hs2_q     <= hs1_q;
                vs2_q     <= vs1_q;
                vis2_q    <= vis1_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dual-port framebuffer. Contents survive reset. A read and a write to
    // the same address on one edge return the old data (read-first).
    // ------------------------------------------------------------------
    logic [2:0] fb_mem [FB_SIZE];
    logic [2:0] rd_data_q;

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            fb_mem[wr_addr] <= wr_data;
        end
        if (tick) begin
            rd_data_q <= fb_mem[rd_addr_q];
        end
    end

    // ------------------------------------------------------------------
    // Pins
    // ------------------------------------------------------------------
    assign VGA_CLK   = phase_q;
    assign VGA_HS    = hs2_q;
    assign VGA_VS    = vs2_q;
    assign VGA_BLANK = vis2_q;
    assign VGA_SYNC  = 1'b0;
    assign VGA_R     = {10{vis2_q & rd_data_q[2]}};
    assign VGA_G     = {10{vis2_q & rd_data_q[1]}};
    assign VGA_B     = {10{vis2_q & rd_data_q[0]}};

endmodule
